uart_tx_arbiter: RTL and testbench

- Controller in front of the UART peripheral's register interface. After reset it programs SPBRG and TXSTA, then shares the transmitter between NUM_REQ byte-stream requesters.
- Uses round-robin arbitration with packet locking: a grant is held until the requester's `last` beat is written to TXREG.
- Paces TXREG writes with the UART's txif_set_en strobe.
- Can re-run configuration on request, but only once the shift register has drained (TRMT).

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and related blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        CFG_BRG,
        CFG_TXSTA,
        IDLE,
        LOCK,
        HOLD,
        DRAIN
    } arb_state_t;

    localparam int unsigned TXSTA_TXEN = 5;
    localparam int unsigned TXSTA_BRGH = 2;
    localparam int unsigned TXSTA_TRMT = 1;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// UART register bus and requester handshake, grouped for the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [7:0]           reg_data_out;
    logic                 spbrg_reg_wr_en;
    logic                 txsta_reg_wr_en;
    logic                 txreg_reg_wr_en;
    logic                 txif_set_en;
    logic                 trmt;
    logic                 cfg_req;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 cfg_done;
    logic                 busy;

    modport master (
        output reg_data_out, spbrg_reg_wr_en, txsta_reg_wr_en, txreg_reg_wr_en,
        output req_ready, grant, cfg_done, busy,
        input  txif_set_en, trmt, cfg_req, req_valid, req_last, req_data
    );

    modport slave (
        input  reg_data_out, spbrg_reg_wr_en, txsta_reg_wr_en, txreg_reg_wr_en,
        input  req_ready, grant, cfg_done, busy,
        output txif_set_en, trmt, cfg_req, req_valid, req_last, req_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid channel after ptr_i, one-hot.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = idx_w(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o
);
    logic found;

    // Search order ptr+1, ptr+2, ..., ptr (mod N); ptr itself comes last.
    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && valid_i[j] && (j == (32'(ptr_i) + i) % N)) begin
                    pick_o[j] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Configures the UART after reset, then shares TXREG between requesters with
// round-robin, packet-locked arbitration paced by the TXIF strobe.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter logic [7:0]  SPBRG_INIT = 8'h00,
    parameter logic [7:0]  TXSTA_INIT = 8'h24,
    parameter int unsigned HOLDOFF    = 2
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned PW = idx_w(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, pick;
    logic [PW-1:0]      ptr_q, ptr_d, g_idx;
    logic [7:0]         hold_q, hold_d;
    logic               pend_q, pend_d;
    logic               last_q, last_d;
    logic               cfg_done_q, cfg_done_d;
    logic               busy_q, busy_d;
    logic [7:0]         g_data;
    logic               g_valid, g_last, accept;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .pick_o  (pick)
    );

    always_comb begin
        g_idx   = '0;
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (grant_q[j]) begin
                g_idx   = PW'(j);
                g_data  = bus.req_data[8*j +: 8];
                g_valid = bus.req_valid[j];
                g_last  = bus.req_last[j];
            end
        end
    end

    assign accept = (state_q == LOCK) && bus.txif_set_en && g_valid;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        last_d     = last_q;
        cfg_done_d = cfg_done_q;
        // A request outside IDLE is deferred so it never splits a packet.
        if (bus.cfg_req && state_q != IDLE) pend_d = 1'b1;
        case (state_q)
            CFG_BRG:   state_d = CFG_TXSTA;
            CFG_TXSTA: begin
                state_d    = IDLE;
                cfg_done_d = 1'b1;
            end
            IDLE: begin
                if (bus.cfg_req || pend_q) begin
                    state_d    = DRAIN;
                    cfg_done_d = 1'b0;
                end else if (|bus.req_valid) begin
                    grant_d = pick;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (accept) begin
                    last_d  = g_last;
                    hold_d  = 8'(HOLDOFF - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    if (last_q) begin
                        ptr_d   = g_idx;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = LOCK;
                    end
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            DRAIN: begin
                if (bus.trmt && bus.txif_set_en) begin
                    pend_d  = 1'b0;
                    state_d = CFG_BRG;
                end
            end
            default: state_d = CFG_BRG;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CFG_BRG;
            grant_q    <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            last_q     <= 1'b0;
            cfg_done_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            cfg_done_q <= cfg_done_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        bus.reg_data_out    = '0;
        bus.spbrg_reg_wr_en = 1'b0;
        bus.txsta_reg_wr_en = 1'b0;
        bus.txreg_reg_wr_en = 1'b0;
        bus.req_ready       = '0;
        if (!rst) begin
            case (state_q)
                CFG_BRG: begin
                    bus.spbrg_reg_wr_en = 1'b1;
                    bus.reg_data_out    = SPBRG_INIT;
                end
                CFG_TXSTA: begin
                    bus.txsta_reg_wr_en = 1'b1;
                    bus.reg_data_out    = TXSTA_INIT;
                end
                LOCK: begin
                    if (accept) begin
                        bus.txreg_reg_wr_en = 1'b1;
                        bus.reg_data_out    = g_data;
                        bus.req_ready       = grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.grant    = rst ? '0 : grant_q;
    assign bus.cfg_done = !rst && cfg_done_q;
    assign bus.busy     = !rst && busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=2, HOLDOFF=2).
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (NR),
        .SPBRG_INIT (8'h00),
        .TXSTA_INIT (8'h24),
        .HOLDOFF    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] pk_data [NR][8];
    int         pk_len  [NR] = '{default: 0};
    int         base    [NR] = '{default: 0};
    int         acc     [NR] = '{default: 0};
    int         wch  [$];
    logic [7:0] wdat [$];
    int         wcyc [$];
    int         cyc = 0;
    int         n_brg = 0;
    int         n_txsta = 0;
    int         inv_err = 0;
    int         fp;
    int         mch;

    // Requester model: presents byte (acc-base) of each loaded packet.
    always begin
        @(posedge clk);
        #2;
        for (int c = 0; c < NR; c++) begin
            fp = acc[c] - base[c];
            bus.req_valid[c] = (fp < pk_len[c]);
            bus.req_last[c]  = (fp == pk_len[c] - 1);
            if (fp < pk_len[c]) bus.req_data[8*c +: 8] = pk_data[c][fp];
            else                bus.req_data[8*c +: 8] = 8'h00;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bus.spbrg_reg_wr_en === 1'b1) n_brg++;
        if (bus.txsta_reg_wr_en === 1'b1) n_txsta++;
        if (bus.txreg_reg_wr_en === 1'b1) begin
            mch = -1;
            for (int c = 0; c < NR; c++)
                if (bus.req_ready[c] === 1'b1) begin
                    acc[c]++;
                    mch = c;
                end
            wch.push_back(mch);
            wdat.push_back(bus.reg_data_out);
            wcyc.push_back(cyc);
        end
        if ((32'(bus.spbrg_reg_wr_en) + 32'(bus.txsta_reg_wr_en) + 32'(bus.txreg_reg_wr_en)) > 1 ||
            (bus.req_ready !== '0 && bus.txreg_reg_wr_en !== 1'b1) ||
            (bus.txreg_reg_wr_en === 1'b1 && bus.req_ready !== bus.grant) ||
            $countones(bus.grant) > 1) begin
            inv_err++;
            $display("invariant violation cyc=%0d strobes=%b%b%b ready=%b grant=%b", cyc,
                     bus.spbrg_reg_wr_en, bus.txsta_reg_wr_en, bus.txreg_reg_wr_en,
                     bus.req_ready, bus.grant);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nextc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pkt(input int c, input int len, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        pk_data[c][0] = b0;
        pk_data[c][1] = b1;
        pk_data[c][2] = b2;
        pk_data[c][3] = b3;
        base[c]       = acc[c];
        pk_len[c]     = len;
    endtask

    task automatic wait_n(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #1;
            if (wdat.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            #1;
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [16:0] snap();
        return {bus.spbrg_reg_wr_en, bus.txsta_reg_wr_en, bus.txreg_reg_wr_en, bus.cfg_done,
                bus.busy, bus.grant, bus.req_ready, bus.reg_data_out};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (snap() !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", snap());
        end
        nextc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.spbrg_reg_wr_en, bus.txsta_reg_wr_en, bus.txreg_reg_wr_en} !== 3'b100 ||
            bus.reg_data_out !== 8'h00 || bus.busy !== 1'b1 || bus.cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL cfg_brg got=%h want strobes=100 data=00 busy=1", snap());
        end
        @(negedge clk);
        checks++;
        if ({bus.spbrg_reg_wr_en, bus.txsta_reg_wr_en, bus.txreg_reg_wr_en} !== 3'b010 ||
            bus.reg_data_out !== 8'h24 || bus.cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL cfg_txsta got=%h want strobes=010 data=24", snap());
        end
        @(negedge clk);
        checks++;
        if (snap() !== 17'h02000) begin
            errors++;
            $display("FAIL cfg_done got=%h want=02000", snap());
        end
    endtask

    task automatic test_single();
        int l0;
        l0 = wdat.size();
        nextc();
        load_pkt(0, 1, 8'hCA, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        checks++;
        if (bus.grant !== 2'b00 || bus.txreg_reg_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got grant=%b txreg=%b want 00 0", bus.grant, bus.txreg_reg_wr_en);
        end
        @(negedge clk);
        checks++;
        if (bus.txreg_reg_wr_en !== 1'b1 || bus.reg_data_out !== 8'hCA ||
            bus.req_ready !== 2'b01 || bus.grant !== 2'b01) begin
            errors++;
            $display("FAIL single_write got txreg=%b data=%h ready=%b grant=%b want 1 ca 01 01",
                     bus.txreg_reg_wr_en, bus.reg_data_out, bus.req_ready, bus.grant);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.grant !== 2'b01 || bus.txreg_reg_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL single_hold got grant=%b txreg=%b want 01 0", bus.grant, bus.txreg_reg_wr_en);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || wdat.size() !== l0 + 1) begin
            errors++;
            $display("FAIL single_release got grant=%b busy=%b writes=%0d want 00 0 %0d",
                     bus.grant, bus.busy, wdat.size(), l0 + 1);
        end
    endtask

    task automatic test_rr();
        int         l0;
        bit         ok;
        int         ech [6] = '{1, 1, 1, 0, 0, 0};
        logic [7:0] ed  [6] = '{8'h20, 8'h21, 8'h22, 8'h10, 8'h11, 8'h12};
        l0 = wdat.size();
        nextc();
        load_pkt(0, 3, 8'h10, 8'h11, 8'h12, 8'h00);
        load_pkt(1, 3, 8'h20, 8'h21, 8'h22, 8'h00);
        wait_n(l0 + 6, 80, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_timeout got writes=%0d want %0d", wdat.size() - l0, 6);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (wch[l0+k] !== ech[k] || wdat[l0+k] !== ed[k]) begin
                    errors++;
                    $display("FAIL rr_order[%0d] got ch=%0d data=%h want ch=%0d data=%h",
                             k, wch[l0+k], wdat[l0+k], ech[k], ed[k]);
                end
            end
            checks++;
            if (wcyc[l0+1] - wcyc[l0] !== 3 || wcyc[l0+3] - wcyc[l0+2] !== 4) begin
                errors++;
                $display("FAIL rr_spacing got %0d/%0d want 3/4",
                         wcyc[l0+1] - wcyc[l0], wcyc[l0+3] - wcyc[l0+2]);
            end
        end
        wait_idle(20, ok);
        nextc();
        l0 = wdat.size();
        load_pkt(1, 1, 8'h41, 8'h00, 8'h00, 8'h00);
        wait_n(l0 + 1, 20, ok);
        wait_idle(20, ok);
        nextc();
        l0 = wdat.size();
        load_pkt(0, 1, 8'h30, 8'h00, 8'h00, 8'h00);
        load_pkt(1, 1, 8'h40, 8'h00, 8'h00, 8'h00);
        wait_n(l0 + 2, 40, ok);
        checks++;
        if (!ok || wch[l0] !== 0 || wdat[l0] !== 8'h30 || wch[l0+1] !== 1 || wdat[l0+1] !== 8'h40) begin
            errors++;
            $display("FAIL rr_ptr_advance got ok=%0d first=%h second=%h want 30 then 40", ok,
                     (wdat.size() > l0) ? wdat[l0] : 8'hxx, (wdat.size() > l0 + 1) ? wdat[l0+1] : 8'hxx);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_txif_stall();
        int l0;
        bit ok;
        bit bad;
        l0  = wdat.size();
        bad = 1'b0;
        nextc();
        load_pkt(0, 3, 8'h50, 8'h51, 8'h52, 8'h00);
        wait_n(l0 + 1, 20, ok);
        nextc();
        bus.txif_set_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.txreg_reg_wr_en !== 1'b0 || bus.grant !== 2'b01) bad = 1'b1;
            nextc();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold got write or grant loss during stall want none");
        end
        bus.txif_set_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.txreg_reg_wr_en !== 1'b1 || bus.reg_data_out !== 8'h51) begin
            errors++;
            $display("FAIL stall_resume got txreg=%b data=%h want 1 51", bus.txreg_reg_wr_en, bus.reg_data_out);
        end
        wait_n(l0 + 3, 30, ok);
        checks++;
        if (!ok || wdat[l0+2] !== 8'h52) begin
            errors++;
            $display("FAIL stall_tail got ok=%0d writes=%0d want 3 writes ending 52", ok, wdat.size() - l0);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_cfg_mid();
        int l0, b0, t0;
        bit ok;
        l0 = wdat.size();
        b0 = n_brg;
        t0 = n_txsta;
        nextc();
        load_pkt(0, 3, 8'h60, 8'h61, 8'h62, 8'h00);
        wait_n(l0 + 1, 20, ok);
        nextc();
        bus.cfg_req = 1'b1;
        bus.trmt    = 1'b0;
        nextc();
        bus.cfg_req = 1'b0;
        wait_n(l0 + 3, 30, ok);
        checks++;
        if (!ok || wdat[l0+1] !== 8'h61 || wdat[l0+2] !== 8'h62 || n_brg !== b0) begin
            errors++;
            $display("FAIL cfg_packet_intact got ok=%0d writes=%0d brg=%0d want 3 writes brg=%0d",
                     ok, wdat.size() - l0, n_brg, b0);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (bus.cfg_done !== 1'b0 || bus.busy !== 1'b1 || n_brg !== b0 || wdat.size() !== l0 + 3) begin
            errors++;
            $display("FAIL cfg_drain_wait got cfg_done=%b busy=%b brg=%0d want 0 1 %0d",
                     bus.cfg_done, bus.busy, n_brg, b0);
        end
        nextc();
        bus.trmt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.cfg_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || n_brg !== b0 + 1 || n_txsta !== t0 + 1 || wdat.size() !== l0 + 3) begin
            errors++;
            $display("FAIL cfg_rerun got ok=%0d brg=%0d txsta=%0d writes=%0d want 1 %0d %0d %0d",
                     ok, n_brg, n_txsta, wdat.size() - l0, b0 + 1, t0 + 1, 3);
        end
    endtask

    task automatic test_reset_mid();
        int l0;
        bit ok;
        l0 = wdat.size();
        nextc();
        load_pkt(0, 4, 8'h70, 8'h71, 8'h72, 8'h73);
        wait_n(l0 + 1, 20, ok);
        nextc();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (snap() !== 17'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%h want=0", snap());
        end
        nextc();
        nextc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.spbrg_reg_wr_en !== 1'b1 || bus.txreg_reg_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_brg got spbrg=%b txreg=%b want 1 0", bus.spbrg_reg_wr_en, bus.txreg_reg_wr_en);
        end
        @(negedge clk);
        checks++;
        if (bus.txsta_reg_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_txsta got %b want 1", bus.txsta_reg_wr_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (wdat.size() !== l0 + 1 || bus.cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_nowrite got writes=%0d cfg_done=%b want 1 1", wdat.size() - l0, bus.cfg_done);
        end
        @(negedge clk);
        checks++;
        if (bus.txreg_reg_wr_en !== 1'b1 || bus.reg_data_out !== 8'h71) begin
            errors++;
            $display("FAIL rst_mid_restart got txreg=%b data=%h want 1 71", bus.txreg_reg_wr_en, bus.reg_data_out);
        end
        wait_n(l0 + 4, 30, ok);
        checks++;
        if (!ok || wdat[l0+3] !== 8'h73) begin
            errors++;
            $display("FAIL rst_mid_tail got ok=%0d writes=%0d want 4", ok, wdat.size() - l0);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_err !== 0) begin
            errors++;
            $display("FAIL invariants got %0d violations want 0", inv_err);
        end
    endtask

    initial begin
        bus.txif_set_en = 1'b1;
        bus.trmt        = 1'b1;
        bus.cfg_req     = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_txif_stall();
        test_cfg_mid();
        test_reset_mid();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
